// File: rtl/mig_truth_table_gen_pkg.sv
// ============================================================================
// mig_truth_table_gen_pkg : shared encodings and types for the MIG truth-table
// generator. Revision: 1.0
// ============================================================================
`default_nettype none

package mig_truth_table_gen_pkg;

  localparam int N_IN_DEFAULT    = 7;
  localparam int N_GATES_DEFAULT = 8;

  localparam int SEL_W  = 4;
  localparam int OP_W   = SEL_W + 1;
  localparam int GATE_W = 3 * OP_W;
  localparam int MT_W   = 7;

  localparam logic [SEL_W-1:0] SEL_CONST0 = 4'd0;
  localparam logic [SEL_W-1:0] SEL_X0     = 4'd1;
  localparam logic [SEL_W-1:0] SEL_W0     = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mig_truth_table_gen_eval.sv
// ============================================================================
// mig_eval : combinational evaluation of the whole gate program for one
// minterm, returning every gate output and the selected output node. Rev 1.0
// ============================================================================
`default_nettype none

module mig_eval
  import mig_truth_table_gen_pkg::*;
#(
  parameter int N_IN    = N_IN_DEFAULT,
  parameter int N_GATES = N_GATES_DEFAULT
) (
  input  logic [MT_W-1:0]           minterm,
  input  logic [N_GATES*GATE_W-1:0] prog,
  input  logic [OP_W-1:0]           out_sel,
  output logic [N_GATES-1:0]        w,
  output logic                      out_bit
);

  // Only gates below lim are visible; anything else reads as constant 0.
  function automatic logic operand(input logic [OP_W-1:0]    op,
                                   input logic [MT_W-1:0]    mt,
                                   input logic [N_GATES-1:0] wv,
                                   input int                 lim);
    int                 sel;
    logic               v;
    logic [MT_W-1:0]    xs;
    logic [N_GATES-1:0] ws;
    sel = int'(op[SEL_W-1:0]);
    v   = 1'b0;
    xs  = '0;
    ws  = '0;
    if (sel >= int'(SEL_W0)) begin
      if ((sel - int'(SEL_W0)) < lim) begin
        ws = wv >> (sel - int'(SEL_W0));
        v  = ws[0];
      end
    end else if ((sel >= int'(SEL_X0)) && ((sel - int'(SEL_X0)) < N_IN)) begin
      xs = mt >> (sel - int'(SEL_X0));
      v  = xs[0];
    end
    return v ^ op[OP_W-1];
  endfunction

  always_comb begin
    logic [N_GATES-1:0] wv;
    logic [GATE_W-1:0]  gw;
    logic               a;
    logic               b;
    logic               c;
    wv = '0;
    gw = '0;
    a  = 1'b0;
    b  = 1'b0;
    c  = 1'b0;
    for (int g = 0; g < N_GATES; g++) begin
      gw = GATE_W'(prog >> (g * GATE_W));
      a  = operand(gw[OP_W-1:0],        minterm, wv, g);
      b  = operand(gw[2*OP_W-1:OP_W],   minterm, wv, g);
      c  = operand(gw[3*OP_W-1:2*OP_W], minterm, wv, g);
      wv = wv | (N_GATES'(maj3(a, b, c)) << g);
    end
    w       = wv;
    out_bit = operand(out_sel, minterm, wv, N_GATES);
  end

endmodule

`default_nettype wire

// File: rtl/mig_truth_table_gen.sv
// ============================================================================
// mig_truth_table_gen : programmable majority-gate network that streams its
// 128-entry truth table as 32 hex nibbles, MSB first. Revision: 1.0
// ============================================================================
`default_nettype none

module mig_truth_table_gen
  import mig_truth_table_gen_pkg::*;
#(
  parameter int N_IN    = N_IN_DEFAULT,
  parameter int N_GATES = N_GATES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_idx,
  input  logic [GATE_W-1:0] cfg_gate,
  input  logic              start,
  input  logic [OP_W-1:0]   out_sel,
  output logic              busy,
  output logic              done,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [3:0]        tt_nibble,
  output logic              tt_last
);

  state_t                    r_state;
  logic [MT_W-1:0]           r_m;
  logic [OP_W-1:0]           r_out_sel;
  logic [3:0]                r_nib;
  logic                      r_cfg_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_tt_valid;
  logic                      r_tt_last;
  logic [N_GATES*GATE_W-1:0] w_prog;
  logic [N_GATES-1:0]        w_gates;
  logic                      w_out_bit;
  logic                      w_unused;

  generate
    for (genvar g = 0; g < N_GATES; g++) begin : g_mem
      logic [GATE_W-1:0] r_gate;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_gate <= '0;
        end else if (cfg_valid && r_cfg_ready && (int'(cfg_idx) == g)) begin
          r_gate <= cfg_gate;
        end
      end
      assign w_prog[g*GATE_W +: GATE_W] = r_gate;
    end
  endgenerate

  mig_eval #(
    .N_IN    (N_IN),
    .N_GATES (N_GATES)
  ) u_eval (
    .minterm (r_m),
    .prog    (w_prog),
    .out_sel (r_out_sel),
    .w       (w_gates),
    .out_bit (w_out_bit)
  );

  // Individual gate outputs are available for inspection but not streamed.
  assign w_unused = ^w_gates;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_m         <= '0;
      r_out_sel   <= '0;
      r_nib       <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tt_valid  <= 1'b0;
      r_tt_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_EVAL;
            r_m         <= 7'h7f;
            r_out_sel   <= out_sel;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_EVAL: begin
          r_nib <= {r_nib[2:0], w_out_bit};
          r_m   <= r_m - 7'd1;
          // Group of four ends on a minterm that is a multiple of four.
          if (r_m[1:0] == 2'b00) begin
            r_state    <= ST_EMIT;
            r_tt_valid <= 1'b1;
            r_tt_last  <= (r_m == 7'd0);
          end
        end
        ST_EMIT: begin
          if (tt_ready) begin
            r_tt_valid <= 1'b0;
            r_tt_last  <= 1'b0;
            r_done     <= r_tt_last;
            r_state    <= r_tt_last ? ST_DONE : ST_EVAL;
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tt_valid  = r_tt_valid;
  assign tt_nibble = r_nib;
  assign tt_last   = r_tt_last;

endmodule

`default_nettype wire
